fir_coe_load_ctrl: RTL

FIR_COE_LOAD_CTRL -- requirements
Module: fir_coe_load_ctrl

---
 rtl/fir_ctrl_pkg.sv | 22 ++
 rtl/fir_coe_bank.sv | 46 ++++
 rtl/fir_coe_load_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding, default sizing and width helper for the FIR
// coefficient load controller.
package fir_ctrl_pkg;

  localparam int unsigned COE_NUM_HALF_DEF = 26;
  localparam int unsigned COE_WDTH_DEF     = 29;
  localparam int unsigned SETTLE_CYC_DEF   = 6;
  localparam int unsigned SWAP_TMO_DEF     = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;

  // Width of a counter that must hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fir_coe_bank.sv
// Double-buffered coefficient storage: beats fill the shadow bank one tap at a
// time, and a single swap strobe copies the whole shadow bank into the active one.
module fir_coe_bank
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned COE_NUM_HALF = COE_NUM_HALF_DEF,
  parameter int unsigned COE_WDTH     = COE_WDTH_DEF,
  parameter int unsigned IDX_W        = cnt_width(COE_NUM_HALF - 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [COE_WDTH-1:0]              wr_data,
  input  logic                             swap,
  output logic [COE_NUM_HALF*COE_WDTH-1:0] coe_arr
);

  logic [COE_WDTH-1:0] shadow [COE_NUM_HALF];
  logic [COE_WDTH-1:0] active [COE_NUM_HALF];

  // NOTE: both banks are register arrays with an explicit reset, so a session
  // cut short by rst can never leave stale taps behind in either bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(COE_NUM_HALF); k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_idx] <= wr_data;
      end
      if (swap) begin
        for (int k = 0; k < int'(COE_NUM_HALF); k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  for (genvar k = 0; k < COE_NUM_HALF; k++) begin : g_flat
    assign coe_arr[COE_WDTH*k +: COE_WDTH] = active[k];
  end

endmodule

// File: rtl/fir_coe_load_ctrl.sv
// Coefficient load controller: collects a full set of symmetric FIR taps, swaps
// them in during a sample gap (or after a timeout) and masks the FIR while it settles.
module fir_coe_load_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned COE_NUM_HALF = COE_NUM_HALF_DEF,
  parameter int unsigned COE_WDTH     = COE_WDTH_DEF,
  parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter int unsigned SWAP_TMO     = SWAP_TMO_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_vld,
  input  logic [COE_WDTH-1:0]              cfg_data,
  output logic                             cfg_rdy,
  input  logic                             bypass_req,
  input  logic                             xvld,
  output logic [COE_NUM_HALF*COE_WDTH-1:0] coe_arr,
  output logic                             fir_bypass,
  output logic                             busy,
  output logic                             swap_done,
  output logic [1:0]                       err_flags
);

  localparam int unsigned IDX_W = cnt_width(COE_NUM_HALF - 1);
  localparam int unsigned TMO_W = cnt_width(SWAP_TMO);
  localparam int unsigned SET_W = cnt_width(SETTLE_CYC);

  localparam logic [IDX_W-1:0] BEAT_LAST = IDX_W'(COE_NUM_HALF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SWAP_TMO - 1);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] beat_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             committed;

  logic open_sess;
  logic abort;
  logic beat_acc;
  logic do_swap;
  logic force_swap;
  logic settle_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    open_sess  = 1'b0;
    abort      = 1'b0;
    beat_acc   = 1'b0;
    do_swap    = 1'b0;
    force_swap = 1'b0;
    settle_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          open_sess = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A restart outranks a coincident beat, which is simply dropped.
        if (cfg_start) begin
          abort = 1'b1;
        end else if (cfg_vld) begin
          beat_acc = 1'b1;
          if (beat_cnt == BEAT_LAST) begin
            state_nxt = ST_WAIT_SWAP;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (cfg_start) begin
          abort     = 1'b1;
          state_nxt = ST_LOAD;
        end else if (!xvld) begin
          do_swap   = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (tmo_cnt >= TMO_LAST) begin
          do_swap    = 1'b1;
          force_swap = 1'b1;
          state_nxt  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt >= SET_LAST) begin
          settle_end = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      committed  <= 1'b0;
      err_flags  <= '0;
      swap_done  <= 1'b0;
      fir_bypass <= 1'b1;
    end else begin
      swap_done <= settle_end;
      // Looks at the next state so the mask rises on the same edge the new
      // taps land and drops exactly when SETTLE is left.
      fir_bypass <= bypass_req | (state_nxt == ST_SETTLE) | ~committed;

      if (do_swap) begin
        committed <= 1'b1;
      end

      if (open_sess) begin
        err_flags <= '0;
      end else begin
        if (abort) begin
          err_flags[0] <= 1'b1;
        end
        if (force_swap) begin
          err_flags[1] <= 1'b1;
        end
      end

      if (open_sess || abort) begin
        beat_cnt <= '0;
      end else if (beat_acc && beat_cnt != BEAT_LAST) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (state != ST_WAIT_SWAP) begin
        tmo_cnt <= '0;
      end else if (xvld && tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (do_swap) begin
        settle_cnt <= '0;
      end else if (state == ST_SETTLE && settle_cnt != SET_LAST) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  assign cfg_rdy = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);

  fir_coe_bank #(
    .COE_NUM_HALF (COE_NUM_HALF),
    .COE_WDTH     (COE_WDTH),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (beat_acc),
    .wr_idx  (beat_cnt),
    .wr_data (cfg_data),
    .swap    (do_swap),
    .coe_arr (coe_arr)
  );

endmodule
